adc_record_ctrl: RTL

//  Parametrised multi-channel ADC record controller in the ADC clock domain.

---
 rtl/adc_record_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/adc_record_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_record_ctrl
// Brief    : Decimating multi-channel ADC record controller. Kept sample sets
//            are serialised channel 0 first into a FIFO write port that can
//            stall, and the record stops after a programmed number of sets.
// Revision : 1.0 - initial release
// ============================================================================
module adc_record_ctrl #(
    parameter int DW    = 8,
    parameter int CH    = 2,
    parameter int LEN_W = 20,
    parameter int DEC_W = 8
) (
    input  logic             clk_32,
    input  logic             rst,
    input  logic             begin_rec,
    input  logic             abort,
    input  logic [LEN_W-1:0] rec_len,
    input  logic [DEC_W-1:0] decim,
    input  logic             en_adc,
    input  logic [CH*DW-1:0] addata,
    input  logic             fifo_full,
    output logic [DW-1:0]    fifo_din,
    output logic             fifo_wr_en,
    output logic             busy,
    output logic             over_re,
    output logic             overflow,
    output logic [LEN_W-1:0] set_cnt
);

    localparam int                c_CIW     = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [c_CIW-1:0]  c_LAST_CH = c_CIW'(CH - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_SERIAL  = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_beg_q;
    logic             r_beg_qq;
    logic [LEN_W-1:0] r_len;
    logic [DEC_W-1:0] r_decim;
    logic [DEC_W-1:0] r_dec_cnt;
    logic [CH*DW-1:0] r_shadow;
    logic [c_CIW-1:0] r_ch_idx;
    logic [LEN_W-1:0] r_set_cnt;
    logic             r_overflow;

    logic             w_start;
    logic             w_active;
    logic             w_take;
    logic             w_wr;
    logic             w_last;
    logic             w_set_done;
    logic             w_load;
    logic             w_drop;
    logic [LEN_W-1:0] w_set_inc;
    logic [DW-1:0]    w_chan [CH];

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_chan
            assign w_chan[g] = r_shadow[g*DW +: DW];
        end
    endgenerate

    // begin_rec is registered once before edge detection, so a start edge
    // is acted on one cycle after it is first seen.
    assign w_start    = r_beg_q & ~r_beg_qq & (r_state == c_ST_IDLE);
    assign w_active   = (r_state == c_ST_CAPTURE) | (r_state == c_ST_SERIAL);
    assign w_take     = w_active & en_adc & (r_dec_cnt == '0);
    assign w_wr       = (r_state == c_ST_SERIAL) & ~fifo_full & ~abort;
    assign w_last     = w_wr & (r_ch_idx == c_LAST_CH);
    assign w_set_inc  = r_set_cnt + LEN_W'(1);
    assign w_set_done = w_last & (w_set_inc == r_len);
    // A take is only accepted while nothing is pending, or in the very cycle
    // the last channel leaves and the record continues.
    assign w_load     = ~abort & w_take &
                        ((r_state == c_ST_CAPTURE) | (w_last & ~w_set_done));
    assign w_drop     = ~abort & w_take & (r_state == c_ST_SERIAL) & ~w_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = (rec_len == '0) ? c_ST_DONE : c_ST_CAPTURE;
                end
            end
            c_ST_CAPTURE: begin
                if (w_take) begin
                    w_state_nxt = c_ST_SERIAL;
                end
            end
            c_ST_SERIAL: begin
                if (w_last) begin
                    if (w_set_done) begin
                        w_state_nxt = c_ST_DONE;
                    end else if (w_take) begin
                        w_state_nxt = c_ST_SERIAL;
                    end else begin
                        w_state_nxt = c_ST_CAPTURE;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (abort && (r_state != c_ST_IDLE)) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge clk_32) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_beg_q    <= 1'b0;
            r_beg_qq   <= 1'b0;
            r_len      <= '0;
            r_decim    <= '0;
            r_dec_cnt  <= '0;
            r_shadow   <= '0;
            r_ch_idx   <= '0;
            r_set_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_beg_q  <= begin_rec;
            r_beg_qq <= r_beg_q;

            if (w_start) begin
                r_len      <= rec_len;
                r_decim    <= decim;
                r_dec_cnt  <= '0;
                r_set_cnt  <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_active && en_adc) begin
                    r_dec_cnt <= (r_dec_cnt == '0) ? r_decim : r_dec_cnt - DEC_W'(1);
                end
                if (w_last) begin
                    r_set_cnt <= w_set_inc;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end

            if (w_load) begin
                r_shadow <= addata;
                r_ch_idx <= '0;
            end else if (w_last) begin
                r_ch_idx <= '0;
            end else if (w_wr) begin
                r_ch_idx <= r_ch_idx + c_CIW'(1);
            end
        end
    end

    assign fifo_din   = w_chan[r_ch_idx];
    assign fifo_wr_en = w_wr;
    assign busy       = w_active;
    assign over_re    = (r_state == c_ST_DONE) & ~abort;
    assign overflow   = r_overflow;
    assign set_cnt    = r_set_cnt;

endmodule
`default_nettype wire
